// File: rtl/dehaze_pkg.sv
// Shared constants and types for the dehazed-frame write path.
// The top-level module overrides the frame geometry through its own parameters.
package dehaze_pkg;

  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
  localparam int ADDR_W    = 19;
  localparam int SKIP      = 8;
  localparam int FRAME_PIX = IMG_W * IMG_H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SKIPPING,
    WRITING,
    DONE
  } wr_state_e;

  // Packs a pixel into the RGB888 word layout used in the frame BRAM.
  function automatic logic [23:0] pixel_word(input pixel_t p);
    return {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Clear/increment counter with a terminal-count flag.
// Used both for the linear pixel address and for the pipeline-fill skip count.
module frame_addr_gen #(
  parameter int WIDTH = 19,
  parameter int TERM  = 0
) (
  input  logic             gen_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge gen_clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign last = (cnt_reg == TERM_V);

endmodule

// File: rtl/dehaze_frame_writer.sv
// Captures one frame of restored RGB pixels into the output BRAM, dropping
// the restoration pipeline-fill beats, and reports a running 24-bit checksum.
module dehaze_frame_writer
  import dehaze_pkg::*;
#(
  parameter int IMG_W  = dehaze_pkg::IMG_W,
  parameter int IMG_H  = dehaze_pkg::IMG_H,
  parameter int ADDR_W = dehaze_pkg::ADDR_W,
  parameter int SKIP   = dehaze_pkg::SKIP
) (
  input  logic              gen_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [23:0]       checksum,
  output logic              err_drop
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;

  wr_state_e         state_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [23:0]       wr_data_reg;
  logic              frame_done_reg;
  logic [23:0]       checksum_reg;
  logic              err_drop_reg;

  pixel_t            pix;
  logic [23:0]       pix_word;
  logic              arm;
  logic              skip_beat;
  logic              write_beat;
  logic [ADDR_W-1:0] pix_cnt;
  logic              pix_last;
  logic              skip_last;
  logic [SKIP_W-1:0] unused_skip_cnt;

  assign pix      = '{r: in_r, g: in_g, b: in_b};
  assign pix_word = pixel_word(pix);

  // start is only honoured between frames; while busy it is ignored.
  assign arm        = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign skip_beat  = (state_reg == SKIPPING) && in_valid;
  assign write_beat = (state_reg == WRITING) && in_valid;

  frame_addr_gen #(
    .WIDTH(ADDR_W),
    .TERM (FRAME_PIX - 1)
  ) u_pix_cnt (
    .gen_clk(gen_clk),
    .rst    (rst),
    .clr    (arm),
    .inc    (write_beat),
    .cnt    (pix_cnt),
    .last   (pix_last)
  );

  generate
    if (SKIP > 0) begin : g_skip
      frame_addr_gen #(
        .WIDTH(SKIP_W),
        .TERM (SKIP - 1)
      ) u_skip_cnt (
        .gen_clk(gen_clk),
        .rst    (rst),
        .clr    (arm),
        .inc    (skip_beat),
        .cnt    (unused_skip_cnt),
        .last   (skip_last)
      );
    end else begin : g_no_skip
      assign unused_skip_cnt = '0;
      assign skip_last       = 1'b1;
    end
  endgenerate

  always_ff @(posedge gen_clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      checksum_reg   <= '0;
      err_drop_reg   <= 1'b0;
    end else begin
      wr_en_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= (SKIP > 0) ? SKIPPING : WRITING;
            checksum_reg <= '0;
            err_drop_reg <= 1'b0;
          end else if (in_valid) begin
            err_drop_reg <= 1'b1;
          end
        end
        SKIPPING: begin
          if (in_valid && skip_last) begin
            state_reg <= WRITING;
          end
        end
        WRITING: begin
          if (in_valid) begin
            wr_en_reg    <= 1'b1;
            wr_addr_reg  <= pix_cnt;
            wr_data_reg  <= pix_word;
            checksum_reg <= checksum_reg + pix_word;
            if (pix_last) begin
              frame_done_reg <= 1'b1;
              state_reg      <= DONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign checksum   = checksum_reg;
  assign err_drop   = err_drop_reg;
  assign busy       = (state_reg == SKIPPING) || (state_reg == WRITING);

endmodule

// File: tb/tb_dehaze_frame_writer.sv
// Directed bench for dehaze_frame_writer on a 4x3 frame with two fill beats,
// checked every cycle against a beat-counting model plus literal expectations.
module tb_dehaze_frame_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int SKIP   = 2;
  localparam int FRAME  = IMG_W * IMG_H;

  logic              gen_clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_r = '0;
  logic [7:0]        in_g = '0;
  logic [7:0]        in_b = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic [23:0]       checksum;
  logic              err_drop;

  int checks = 0;
  int errors = 0;

  dehaze_frame_writer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .SKIP  (SKIP)
  ) dut (
    .gen_clk   (gen_clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .checksum  (checksum),
    .err_drop  (err_drop)
  );

  always #5 gen_clk = ~gen_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is "open" after start until SKIP+FRAME valid beats have
  // been consumed; beat n (n >= SKIP) lands at address n-SKIP.
  bit          model_ready = 0;
  bit          armed = 0;
  int          beats = 0;
  logic        exp_wr_en = 0;
  logic [31:0] exp_addr = 0;
  logic [23:0] exp_data = 0;
  logic [23:0] exp_sum = 0;
  logic        exp_done = 0;
  logic        exp_err = 0;
  logic        exp_busy = 0;

  always @(posedge gen_clk) begin
    exp_wr_en = 1'b0;
    exp_done  = 1'b0;
    if (rst) begin
      model_ready = 1;
      armed = 0;
      beats = 0;
      exp_addr = 0;
      exp_data = 0;
      exp_sum = 0;
      exp_err = 0;
    end else if (!(armed && beats < SKIP + FRAME)) begin
      if (start) begin
        armed = 1;
        beats = 0;
        exp_sum = 0;
        exp_err = 0;
      end else if (in_valid) begin
        exp_err = 1;
      end
    end else if (in_valid) begin
      if (beats >= SKIP) begin
        exp_wr_en = 1'b1;
        exp_addr  = beats - SKIP;
        exp_data  = {in_r, in_g, in_b};
        exp_sum   = exp_sum + {in_r, in_g, in_b};
        exp_done  = (beats - SKIP == FRAME - 1);
      end
      beats++;
    end
    exp_busy = armed && beats < SKIP + FRAME;
  end

  int          done_cnt = 0;
  logic [23:0] done_sum = 0;
  logic [31:0] done_addr = 0;

  always @(negedge gen_clk) begin
    if (model_ready) begin
      check("wr_en", {31'b0, wr_en}, {31'b0, exp_wr_en});
      check("wr_addr", {28'b0, wr_addr}, exp_addr);
      check("wr_data", {8'b0, wr_data}, {8'b0, exp_data});
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("frame_done", {31'b0, frame_done}, {31'b0, exp_done});
      check("checksum", {8'b0, checksum}, {8'b0, exp_sum});
      check("err_drop", {31'b0, err_drop}, {31'b0, exp_err});
      if (wr_en)
        $display("write addr=%0d data=%06h checksum=%06h done=%0b", wr_addr, wr_data, checksum, frame_done);
      if (frame_done) begin
        done_cnt++;
        done_sum  = checksum;
        done_addr = {28'b0, wr_addr};
      end
    end
  end

  task automatic drive(input logic st, input logic v, input logic [7:0] px);
    @(negedge gen_clk);
    start = st;
    in_valid = v;
    in_r = px;
    in_g = px;
    in_b = px;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset and reset-state values
    @(negedge gen_clk);
    rst = 1'b1;
    idle(2);
    @(negedge gen_clk);
    rst = 1'b0;
    check("reset_wr_en", {31'b0, wr_en}, 32'd0);
    check("reset_checksum", {8'b0, checksum}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);

    // Frame 1: contiguous beats; sum of {k,k,k} for k=2..13 is 90*0x010101
    done_cnt = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) drive(1'b0, 1'b1, 8'(k));
    idle(3);
    check("f1_done_cnt", done_cnt, 32'd1);
    check("f1_done_addr", done_addr, 32'd11);
    check("f1_checksum", {8'b0, done_sum}, 32'h005A5A5A);
    check("f1_busy_after", {31'b0, busy}, 32'd0);

    // Frame 2: same data with a gap after every beat
    done_cnt = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, 8'(k));
      drive(1'b0, 1'b0, 8'hAA);
    end
    idle(2);
    check("f2_done_cnt", done_cnt, 32'd1);
    check("f2_checksum", {8'b0, done_sum}, 32'h005A5A5A);

    // Drops in IDLE, start clears the error, then reset mid-frame
    @(negedge gen_clk);
    rst = 1'b1;
    @(negedge gen_clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    idle(1);
    check("idle_err_drop", {31'b0, err_drop}, 32'd1);
    check("idle_no_write", {31'b0, wr_en}, 32'd0);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    check("start_clears_err", {31'b0, err_drop}, 32'd0);
    for (int k = 1; k < 7; k++) drive(1'b0, 1'b1, 8'(k));
    @(negedge gen_clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_r = 8'h07;
    in_g = 8'h07;
    in_b = 8'h07;
    rst = 1'b1;
    @(negedge gen_clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_checksum", {8'b0, checksum}, 32'd0);
    drive(1'b0, 1'b1, 8'h08);
    drive(1'b0, 1'b1, 8'h09);
    idle(1);
    check("post_rst_err_drop", {31'b0, err_drop}, 32'd1);

    // Frame 3: start pulsed alongside the beat written at address 6
    done_cnt = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) drive(k == 8, 1'b1, 8'(k));
    idle(2);
    check("f3_done_cnt", done_cnt, 32'd1);
    check("f3_done_addr", done_addr, 32'd11);
    check("f3_checksum", {8'b0, done_sum}, 32'h005A5A5A);

    // Frame 4: restart from DONE with all-ones pixels; 12*0xFFFFFF mod 2^24
    done_cnt = 0;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hFF);
    check("f4_checksum_cleared", {8'b0, checksum}, 32'd0);
    for (int k = 1; k < 14; k++) drive(1'b0, 1'b1, 8'hFF);
    idle(3);
    check("f4_done_cnt", done_cnt, 32'd1);
    check("f4_done_addr", done_addr, 32'd11);
    check("f4_checksum", {8'b0, done_sum}, 32'h00FFFFF4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
